// File: rtl/shift_reg_n_pkg.sv
// Shared encodings for the shift register family and the serial blocks
// built on top of it.
//   MODE_*  : manual operation codes driven on the 'mode' port
//   state_e : burst controller states
package shift_reg_n_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/shift_reg_n_burst_counter.sv
// burst_counter: up-counter over 0..WIDTH-1 with clear, enable and a
// terminal-count flag.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   clr_i      : synchronous clear (wins over en_i)
//   en_i       : count enable
//   cnt_o      : current count, $clog2(WIDTH) bits
//   tc_o       : high while cnt_o == WIDTH-1
module burst_counter #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o  = (cnt_q == CW'(WIDTH - 1));
    assign cnt_o = cnt_q;

    // Saturates at the terminal value so the count can never wrap, even if
    // a user keeps the enable high past the last step.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !tc_o)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/shift_reg_n.sv
// shift_reg_n: universal WIDTH-bit shift register with a full-duplex burst
// mode (load a word, shift it out over WIDTH enabled edges while capturing
// sin).
//   clk, reset : rising-edge clock, synchronous active-high reset
//   en         : global enable; 0 freezes state, data and counter
//   mode       : manual op when idle (hold / shl / shr / load)
//   d          : parallel load data
//   sin        : serial input
//   start      : burst request, accepted only when idle with en=1
//   q          : register contents
//   sout       : next bit to transmit (MSB or LSB end of q)
//   busy       : burst in progress
//   done       : one-cycle pulse after the final burst shift
module shift_reg_n
    import shift_reg_n_pkg::*;
#(
    parameter int unsigned           WIDTH     = 8,
    parameter bit                    MSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    if (WIDTH < 2) begin : g_width_chk
        $error("shift_reg_n: WIDTH must be >= 2");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] shl_val, shr_val, burst_val;

    assign shl_val   = {q_q[WIDTH-2:0], sin};
    assign shr_val   = {sin, q_q[WIDTH-1:1]};
    assign burst_val = MSB_FIRST ? shl_val : shr_val;

    burst_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

    // State register (with data and done pulse)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            q_q     <= RESET_VAL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en && start)  state_d = ST_SHIFT;
            ST_SHIFT: if (en && cnt_tc) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        q_d     = q_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Counter is held at zero while idle so every burst starts at 0.
                cnt_clr = 1'b1;
                if (en) begin
                    if (start) begin
                        q_d = d;
                    end else begin
                        case (mode)
                            MODE_SHL:  q_d = shl_val;
                            MODE_SHR:  q_d = shr_val;
                            MODE_LOAD: q_d = d;
                            default:   q_d = q_q;
                        endcase
                    end
                end
            end
            ST_SHIFT: begin
                if (en) begin
                    q_d    = burst_val;
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        done_d  = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign q    = q_q;
    assign sout = MSB_FIRST ? q_q[WIDTH-1] : q_q[0];
    assign busy = (state_q == ST_SHIFT);
    assign done = done_q;

endmodule
